fetch_pipe: RTL

FETCH_PIPE -- requirements
Module: fetch_pipe

---
 rtl/fetch_pipe.sv | 139 +++++++++++++
 1 files changed

// File: rtl/fetch_pipe.sv
// fetch_pipe: single-issue instruction fetch stage.
//
// Walks a program counter through an instruction ROM, registers each fetched
// word for decode, honours downstream stalls, redirects on absolute jumps
// (and optionally PC-relative branches), and stops on the all-ones halt word.
//
// Parameters:
//   D          program counter width
//   W          instruction word width
//   START_ADDR PC value loaded at reset
//
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   start           one-cycle pulse that begins fetching from IDLE
//   stall           downstream hold request
//   imem_addr       ROM address (current PC, combinational)
//   imem_data       ROM word for imem_addr, same cycle
//   instr_out       registered instruction for decode
//   instr_pc        address instr_out was fetched from
//   instr_valid     instr_out is live
//   jump_en         absolute jump taken by instr_out
//   jump_target     absolute jump destination
//   rel_en          relative branch taken by instr_out
//   rel_offset      signed offset relative to instr_pc
//   done            sticky halt indicator
//
// Build option: define FETCH_REL_BRANCH_EN to enable relative branches; when
// undefined, rel_en/rel_offset are present but ignored.

module fetch_pipe #(
    parameter int unsigned D          = 10,
    parameter int unsigned W          = 9,
    parameter logic [D-1:0] START_ADDR = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stall,
    output logic [D-1:0] imem_addr,
    input  logic [W-1:0] imem_data,
    output logic [W-1:0] instr_out,
    output logic [D-1:0] instr_pc,
    output logic         instr_valid,
    input  logic         jump_en,
    input  logic [D-1:0] jump_target,
    input  logic         rel_en,
    input  logic [D-1:0] rel_offset,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state, state_next;
    logic [D-1:0]  pc, pc_next;
    logic [W-1:0]  instr_next;
    logic [D-1:0]  instr_pc_next;
    logic          valid_next;
    logic          done_next;
    logic          rel_take;
    logic [D-1:0]  rel_dest;

    assign imem_addr = pc;

    // Two's-complement add wraps modulo 2^D naturally at width D.
    assign rel_dest = instr_pc + rel_offset;

`ifdef FETCH_REL_BRANCH_EN
    assign rel_take = rel_en;
`else
    logic unused_rel;
    assign rel_take   = 1'b0;
    assign unused_rel = ^{rel_en, rel_offset};
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= START_ADDR;
            instr_out   <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            instr_out   <= instr_next;
            instr_pc    <= instr_pc_next;
            instr_valid <= valid_next;
            done        <= done_next;
        end
    end

    always_comb begin
        state_next    = state;
        pc_next       = pc;
        instr_next    = instr_out;
        instr_pc_next = instr_pc;
        valid_next    = instr_valid;
        done_next     = done;

        unique case (state)
            IDLE: begin
                valid_next = 1'b0;
                if (start) state_next = RUN;
            end
            RUN: begin
                // Priority: halt word > jump > relative branch > stall > fetch.
                // Redirects only apply to a live instruction in instr_out.
                if (instr_valid && (instr_out == '1)) begin
                    state_next = HALT;
                    done_next  = 1'b1;
                    valid_next = 1'b0;
                end else if (instr_valid && jump_en) begin
                    pc_next    = jump_target;
                    valid_next = 1'b0;
                end else if (instr_valid && rel_take) begin
                    pc_next    = rel_dest;
                    valid_next = 1'b0;
                end else if (!stall) begin
                    instr_next    = imem_data;
                    instr_pc_next = pc;
                    valid_next    = 1'b1;
                    pc_next       = pc + 1'b1;
                end
            end
            HALT: begin
                done_next = 1'b1;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
